ovr_filter: RTL and testbench

- Oversample filter directly downstream of the ADC clock-domain synchronizer. All logic runs in the system clock domain.
- Consumes the synchronizer's per-channel data-valid pulses and its two shared data buses. Bus A carries channels 0..N_ADC/2-1; bus B carries channels N_ADC/2..N_ADC-1.
- Averages 2^os consecutive samples per channel. Emits one averaged word per channel per window on matching output buses, toward the PID stage.

---
 rtl/ovr_filter_pkg.sv | 19 +
 rtl/ovr_accum.sv | 86 ++++++++
 rtl/ovr_filter.sv | 93 +++++++++
 tb/tb_ovr_filter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ovr_filter_pkg.sv
// Shared defaults and derived widths for the ovr_filter oversample filter.
// Rounding build option: define OVR_FILTER_ROUND_EN.
package ovr_filter_pkg;

  localparam int unsigned DEF_W_DATA = 18;
  localparam int unsigned DEF_N_ADC  = 8;
  localparam int unsigned DEF_W_OS   = 3;
  localparam int unsigned DEF_MAX_OS = 7;

  // Wide enough to hold 2^max_os full-scale samples without overflow.
  function automatic int unsigned acc_width(input int unsigned w_data, input int unsigned max_os);
    return w_data + max_os;
  endfunction

  function automatic int unsigned chan_width(input int unsigned n_adc);
    return (n_adc > 1) ? $clog2(n_adc) : 1;
  endfunction

endpackage

// File: rtl/ovr_accum.sv
// Single-channel accumulator: window counter, oversample exponent and averaged output register.
// Define OVR_FILTER_ROUND_EN to round half-up instead of truncating toward negative infinity.
module ovr_accum
  import ovr_filter_pkg::*;
#(
  parameter int unsigned W_DATA = DEF_W_DATA,
  parameter int unsigned W_OS   = DEF_W_OS,
  parameter int unsigned MAX_OS = DEF_MAX_OS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [W_DATA-1:0] i_data,
  input  logic              i_os_wr,
  input  logic [W_OS-1:0]   i_os_val,
  output logic              o_valid,
  output logic [W_DATA-1:0] o_data
);

  localparam int unsigned W_ACC = acc_width(W_DATA, MAX_OS);
  localparam int unsigned W_CNT = MAX_OS + 1;

  logic signed [W_ACC-1:0] r_acc;
  logic [W_CNT-1:0]        r_cnt;
  logic [W_OS-1:0]         r_os;
  logic                    r_valid;
  logic [W_DATA-1:0]       r_data;

  logic [W_OS-1:0]         w_os;
  logic signed [W_ACC-1:0] w_acc_base;
  logic [W_CNT-1:0]        w_cnt_base;
  logic signed [W_ACC-1:0] w_sum;
  logic [W_CNT-1:0]        w_cnt_next;
  logic [W_CNT-1:0]        w_target;
  logic                    w_done;
  logic signed [W_ACC:0]   w_half;
  logic signed [W_ACC:0]   w_rnd;
  logic [W_DATA-1:0]       w_avg;

  // An exponent write restarts the window; a coincident sample becomes its first sample.
  always_comb begin
    w_os       = i_os_wr ? i_os_val : r_os;
    w_acc_base = i_os_wr ? '0 : r_acc;
    w_cnt_base = i_os_wr ? '0 : r_cnt;
    w_sum      = w_acc_base + {{MAX_OS{i_data[W_DATA-1]}}, i_data};
    w_cnt_next = w_cnt_base + W_CNT'(1);
    w_target   = W_CNT'(1) << w_os;
    w_done     = i_valid && (w_cnt_next == w_target);
`ifdef OVR_FILTER_ROUND_EN
    w_half     = (w_os != '0) ? ((W_ACC + 1)'(1) << (w_os - W_OS'(1))) : '0;
`else
    w_half     = '0;
`endif
    // One extra bit so the rounding offset cannot wrap a full-scale positive sum.
    w_rnd      = $signed({w_sum[W_ACC-1], w_sum}) + w_half;
    w_avg      = W_DATA'(w_rnd >>> w_os);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_os    <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_os    <= w_os;
      r_valid <= w_done;
      if (w_done) begin
        r_data <= w_avg;
        r_acc  <= '0;
        r_cnt  <= '0;
      end else if (i_valid) begin
        r_acc <= w_sum;
        r_cnt <= w_cnt_next;
      end else begin
        r_acc <= w_acc_base;
        r_cnt <= w_cnt_base;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/ovr_filter.sv
// Oversample filter top: half-bus steering with lowest-index priority, per-channel averaging,
// and A/B output muxing. Define OVR_FILTER_ROUND_EN for round-half-up averages.
module ovr_filter
  import ovr_filter_pkg::*;
#(
  parameter int unsigned W_DATA = DEF_W_DATA,
  parameter int unsigned N_ADC  = DEF_N_ADC,
  parameter int unsigned W_OS   = DEF_W_OS,
  parameter int unsigned MAX_OS = DEF_MAX_OS
) (
  input  logic                          sys_clk_in,
  input  logic                          reset_in,
  input  logic [N_ADC-1:0]              data_valid_in,
  input  logic [W_DATA-1:0]             data_a_in,
  input  logic [W_DATA-1:0]             data_b_in,
  input  logic [chan_width(N_ADC)-1:0]  os_chan_in,
  input  logic [W_OS-1:0]               os_value_in,
  input  logic                          os_update_in,
  output logic [N_ADC-1:0]              data_valid_out,
  output logic [W_DATA-1:0]             data_a_out,
  output logic [W_DATA-1:0]             data_b_out
);

  localparam int unsigned W_CH   = chan_width(N_ADC);
  localparam int          N_HALF = int'(N_ADC / 2);
  localparam logic [W_OS-1:0] OS_MAX = W_OS'(MAX_OS);

  logic [N_ADC-1:0]  w_take;
  logic [N_ADC-1:0]  w_os_wr;
  logic [N_ADC-1:0]  w_valid;
  logic [W_DATA-1:0] w_data [N_ADC];
  logic [W_OS-1:0]   w_os_clamped;
  logic [W_CH-1:0]   w_sel_a;
  logic [W_CH-1:0]   w_sel_b;
  logic [W_CH-1:0]   r_sel_a;
  logic [W_CH-1:0]   r_sel_b;

  // Scan each half from the top down so the lowest asserted index is the one left standing.
  always_comb begin
    w_take = '0;
    for (int i = N_HALF - 1; i >= 0; i--) begin
      if (data_valid_in[i]) w_take[N_HALF-1:0] = N_HALF'(1) << i;
    end
    for (int i = int'(N_ADC) - 1; i >= N_HALF; i--) begin
      if (data_valid_in[i]) w_take[N_ADC-1:N_HALF] = N_HALF'(1) << (i - N_HALF);
    end
    w_os_clamped = (os_value_in > OS_MAX) ? OS_MAX : os_value_in;
    w_os_wr      = os_update_in ? (N_ADC'(1) << os_chan_in) : '0;
  end

  for (genvar g = 0; g < int'(N_ADC); g++) begin : g_ch
    ovr_accum #(
      .W_DATA (W_DATA),
      .W_OS   (W_OS),
      .MAX_OS (MAX_OS)
    ) u_accum (
      .i_clk    (sys_clk_in),
      .i_rst    (reset_in),
      .i_valid  (w_take[g]),
      .i_data   ((g < N_HALF) ? data_a_in : data_b_in),
      .i_os_wr  (w_os_wr[g]),
      .i_os_val (w_os_clamped),
      .o_valid  (w_valid[g]),
      .o_data   (w_data[g])
    );
  end

  // The last channel to pulse in each half keeps driving its bus, so the bus holds between pulses.
  always_comb begin
    w_sel_a = r_sel_a;
    w_sel_b = r_sel_b;
    for (int i = 0; i < N_HALF; i++) begin
      if (w_valid[i]) w_sel_a = W_CH'(i);
    end
    for (int i = N_HALF; i < int'(N_ADC); i++) begin
      if (w_valid[i]) w_sel_b = W_CH'(i);
    end
    data_valid_out = w_valid;
    data_a_out     = w_data[w_sel_a];
    data_b_out     = w_data[w_sel_b];
  end

  always_ff @(posedge sys_clk_in) begin
    if (reset_in) begin
      r_sel_a <= '0;
      r_sel_b <= W_CH'(N_HALF);
    end else begin
      r_sel_a <= w_sel_a;
      r_sel_b <= w_sel_b;
    end
  end

endmodule

// File: tb/tb_ovr_filter.sv
// Bench for ovr_filter: directed scenarios plus random traffic against a window-average model.
module tb_ovr_filter;

  localparam int W_DATA = 18;
  localparam int N_ADC  = 8;
  localparam int N_HALF = 4;
  localparam int W_OS   = 3;
  localparam int MAX_OS = 5;
`ifdef OVR_FILTER_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [N_ADC-1:0]  dv;
  logic [W_DATA-1:0] da, db;
  logic [2:0]        och;
  logic [W_OS-1:0]   oval;
  logic              oupd;
  logic [N_ADC-1:0]  dvo;
  logic [W_DATA-1:0] dao, dbo;

  int errors = 0;
  int checks = 0;

  longint            m_sum [N_ADC];
  int                m_cnt [N_ADC];
  int                m_os  [N_ADC];
  logic [N_ADC-1:0]  e_valid;
  logic [W_DATA-1:0] e_a, e_b;

  always #5 clk = ~clk;

  ovr_filter #(
    .W_DATA (W_DATA),
    .N_ADC  (N_ADC),
    .W_OS   (W_OS),
    .MAX_OS (MAX_OS)
  ) dut (
    .sys_clk_in     (clk),
    .reset_in       (rst),
    .data_valid_in  (dv),
    .data_a_in      (da),
    .data_b_in      (db),
    .os_chan_in     (och),
    .os_value_in    (oval),
    .os_update_in   (oupd),
    .data_valid_out (dvo),
    .data_a_out     (dao),
    .data_b_out     (dbo)
  );

  function automatic longint fdiv(input longint s, input longint d);
    longint q;
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  task automatic chk(input string tag, input logic [W_DATA-1:0] got, input logic [W_DATA-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Window-average model: collect samples per channel, emit floor (or rounded) mean at 2^os.
  task automatic model(input logic [N_ADC-1:0] v, input logic [W_DATA-1:0] a,
                       input logic [W_DATA-1:0] b, input logic upd, input logic [2:0] ch,
                       input logic [W_OS-1:0] val, input logic r);
    int lo, hi;
    longint d, avg;
    e_valid = '0;
    if (r) begin
      for (int c = 0; c < N_ADC; c++) begin
        m_sum[c] = 0; m_cnt[c] = 0; m_os[c] = 0;
      end
      e_a = '0;
      e_b = '0;
      return;
    end
    lo = -1;
    hi = -1;
    for (int c = 0; c < N_HALF; c++) if (v[c] && lo < 0) lo = c;
    for (int c = N_HALF; c < N_ADC; c++) if (v[c] && hi < 0) hi = c;
    for (int c = 0; c < N_ADC; c++) begin
      if (upd && int'(ch) == c) begin
        m_os[c]  = (int'(val) > MAX_OS) ? MAX_OS : int'(val);
        m_sum[c] = 0;
        m_cnt[c] = 0;
      end
      if (c == lo || c == hi) begin
        m_sum[c] += (c < N_HALF) ? longint'($signed(a)) : longint'($signed(b));
        m_cnt[c]++;
        d = longint'(1) << m_os[c];
        if (longint'(m_cnt[c]) == d) begin
          avg = fdiv(m_sum[c] + ((ROUND && m_os[c] > 0) ? d / 2 : 0), d);
          e_valid[c] = 1'b1;
          if (c < N_HALF) e_a = avg[W_DATA-1:0];
          else            e_b = avg[W_DATA-1:0];
          m_sum[c] = 0;
          m_cnt[c] = 0;
        end
      end
    end
  endtask

  task automatic step(input logic [N_ADC-1:0] v, input logic [W_DATA-1:0] a,
                      input logic [W_DATA-1:0] b, input logic upd, input logic [2:0] ch,
                      input logic [W_OS-1:0] val, input logic r);
    dv = v; da = a; db = b; oupd = upd; och = ch; oval = val; rst = r;
    @(posedge clk);
    #1;
    model(v, a, b, upd, ch, val, r);
    chk("valid", W_DATA'(dvo), W_DATA'(e_valid));
    chk("bus_a", dao, e_a);
    chk("bus_b", dbo, e_b);
  endtask

  task automatic smp(input logic [N_ADC-1:0] v, input logic [W_DATA-1:0] a,
                     input logic [W_DATA-1:0] b);
    step(v, a, b, 1'b0, 3'd0, '0, 1'b0);
  endtask

  task automatic wr(input logic [2:0] ch, input logic [W_OS-1:0] val);
    step('0, '0, '0, 1'b1, ch, val, 1'b0);
  endtask

  initial begin
    logic [W_DATA-1:0] neg3, neg4, e_sgn, e_clamp;
    neg3 = -18'sd3;
    neg4 = -18'sd4;
    e_sgn   = ROUND ? neg3 : neg4;
    e_clamp = ROUND ? 18'd17 : 18'd16;

    step('0, '0, '0, 1'b0, 3'd0, '0, 1'b1);
    step('0, '0, '0, 1'b0, 3'd0, '0, 1'b1);
    chk("rst_valid", W_DATA'(dvo), '0);
    chk("rst_a", dao, '0);

    // Pass-through at os = 0.
    smp(8'h01, 18'h00123, '0);
    chk("pt_valid", W_DATA'(dvo), 18'h01);
    chk("pt_a", dao, 18'h00123);
    smp('0, '0, '0);
    chk("pt_drop", W_DATA'(dvo), '0);
    chk("pt_hold", dao, 18'h00123);

    // Four-sample average on ch2: 101 / 4 -> 25 either way.
    wr(3'd2, 3'd2);
    smp(8'h04, 18'd10, '0);
    smp('0, '0, '0);
    smp(8'h04, 18'd20, '0);
    smp(8'h04, 18'd30, '0);
    chk("avg_early", W_DATA'(dvo), '0);
    smp(8'h04, 18'd41, '0);
    chk("avg_valid", W_DATA'(dvo), 18'h04);
    chk("avg_a", dao, 18'd25);

    // Signed pair on ch5 via bus B.
    wr(3'd5, 3'd1);
    smp(8'h20, '0, neg3);
    smp(8'h20, '0, neg4);
    chk("sgn_valid", W_DATA'(dvo), 18'h20);
    chk("sgn_b", dbo, e_sgn);

    // Independent halves, lowest index wins in each.
    wr(3'd2, 3'd0);
    wr(3'd5, 3'd0);
    smp(8'b0011_0110, 18'd7, 18'd9);
    chk("pri_valid", W_DATA'(dvo), 18'b0001_0010);
    chk("pri_a", dao, 18'd7);
    chk("pri_b", dbo, 18'd9);

    // Mid-window exponent write on ch1 discards the partial window.
    wr(3'd1, 3'd3);
    for (int k = 1; k <= 5; k++) smp(8'h02, W_DATA'(k * 3), '0);
    step(8'h02, 18'd100, '0, 1'b1, 3'd1, 3'd1, 1'b0);
    chk("mid_nopulse", W_DATA'(dvo), '0);
    smp(8'h02, 18'd50, '0);
    chk("mid_valid", W_DATA'(dvo), 18'h02);
    chk("mid_a", dao, 18'd75);

    // Exponent 7 clamps to 5: 32-sample window on ch3.
    wr(3'd3, 3'd7);
    for (int k = 1; k <= 31; k++) smp(8'h08, W_DATA'(k), '0);
    chk("clamp_early", W_DATA'(dvo), '0);
    smp(8'h08, 18'd32, '0);
    chk("clamp_valid", W_DATA'(dvo), 18'h08);
    chk("clamp_a", dao, e_clamp);
    for (int k = 0; k < 10; k++) smp(8'h08, 18'd1000, '0);
    step('0, '0, '0, 1'b0, 3'd0, '0, 1'b1);
    chk("rst2_valid", W_DATA'(dvo), '0);
    chk("rst2_a", dao, '0);
    chk("rst2_b", dbo, '0);
    smp(8'h08, 18'd77, '0);
    chk("rst2_pt_valid", W_DATA'(dvo), 18'h08);
    chk("rst2_pt_a", dao, 18'd77);

    // Random traffic, exponent writes and occasional resets.
    for (int n = 0; n < 4000; n++) begin
      logic [N_ADC-1:0] v;
      v = ($urandom_range(0, 2) == 0) ? N_ADC'($urandom) : '0;
      step(v, W_DATA'($urandom), W_DATA'($urandom), ($urandom_range(0, 15) == 0),
           3'($urandom), W_OS'($urandom_range(0, 7)), ($urandom_range(0, 999) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
